// File: rtl/tap_ctrl_ir_dr.sv
// IEEE 1149.1 TAP controller with IR and BYPASS/IDCODE/USER data registers, serial TDI/TDO.
// Capture/shift/update act on the GCLK edge leaving each state; TDO is combinational; TMS/TDI have no backpressure.
module tap_ctrl_ir_dr #(
    parameter int                   IR_WIDTH     = 4,
    parameter int                   DR_WIDTH     = 8,
    parameter logic [31:0]          IDCODE_VAL   = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0]  INSTR_IDCODE = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]  INSTR_USER   = IR_WIDTH'(2)
) (
    input  logic                GCLK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          state_obs,
    output logic [IR_WIDTH-1:0] ir_out,
    input  logic [DR_WIDTH-1:0] user_dr_in,
    output logic [DR_WIDTH-1:0] user_dr_out,
    output logic                update_dr_pulse
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    // The two LSBs captured into the IR are the fixed 1149.1 "01" pattern.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_q, idcode_d;
    logic [DR_WIDTH-1:0] user_sr_q, user_sr_d;
    logic [DR_WIDTH-1:0] user_out_q, user_out_d;
    logic                pulse_q, pulse_d;

    logic                sel_idcode;
    logic                sel_user;
    logic [DR_WIDTH-1:0] user_shifted;

    assign sel_idcode = (ir_q == INSTR_IDCODE);
    assign sel_user   = (ir_q == INSTR_USER);

    if (DR_WIDTH == 1) begin : g_user_narrow
        assign user_shifted = TDI;
    end else begin : g_user_wide
        assign user_shifted = {TDI, user_sr_q[DR_WIDTH-1:1]};
    end

    always_ff @(posedge GCLK or negedge TRST) begin
        if (!TRST) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = TMS ? TLR    : RTI;
            RTI:    state_d = TMS ? SEL_DR : RTI;
            SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = TMS ? SEL_DR : RTI;
            SEL_IR: state_d = TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        ir_sr_d    = ir_sr_q;
        ir_d       = ir_q;
        bypass_d   = bypass_q;
        idcode_d   = idcode_q;
        user_sr_d  = user_sr_q;
        user_out_d = user_out_q;
        pulse_d    = 1'b0;

        case (state_q)
            CAP_IR: ir_sr_d = IR_CAPTURE;
            SH_IR:  ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
            UPD_IR: ir_d    = ir_sr_q;
            CAP_DR: begin
                if (sel_idcode) begin
                    idcode_d = IDCODE_VAL;
                end else if (sel_user) begin
                    user_sr_d = user_dr_in;
                end else begin
                    bypass_d = 1'b0;
                end
            end
            SH_DR: begin
                if (sel_idcode) begin
                    idcode_d = {TDI, idcode_q[31:1]};
                end else if (sel_user) begin
                    user_sr_d = user_shifted;
                end else begin
                    bypass_d = TDI;
                end
            end
            UPD_DR: begin
                if (sel_user) begin
                    user_out_d = user_sr_q;
                    pulse_d    = 1'b1;
                end
            end
            default: ;
        endcase

        // Any edge landing in TLR (TMS walk or staying there) re-selects IDCODE.
        if (state_d == TLR) begin
            ir_d = INSTR_IDCODE;
        end
    end

    always_ff @(posedge GCLK or negedge TRST) begin
        if (!TRST) begin
            ir_sr_q    <= '0;
            ir_q       <= INSTR_IDCODE;
            bypass_q   <= 1'b0;
            idcode_q   <= '0;
            user_sr_q  <= '0;
            user_out_q <= '0;
            pulse_q    <= 1'b0;
        end else begin
            ir_sr_q    <= ir_sr_d;
            ir_q       <= ir_d;
            bypass_q   <= bypass_d;
            idcode_q   <= idcode_d;
            user_sr_q  <= user_sr_d;
            user_out_q <= user_out_d;
            pulse_q    <= pulse_d;
        end
    end

    always_comb begin
        TDO = 1'b0;
        case (state_q)
            SH_IR: TDO = ir_sr_q[0];
            SH_DR: begin
                if (sel_idcode) begin
                    TDO = idcode_q[0];
                end else if (sel_user) begin
                    TDO = user_sr_q[0];
                end else begin
                    TDO = bypass_q;
                end
            end
            default: TDO = 1'b0;
        endcase
    end

    assign TDO_EN          = (state_q == SH_IR) || (state_q == SH_DR);
    assign state_obs       = state_q;
    assign ir_out          = ir_q;
    assign user_dr_out     = user_out_q;
    assign update_dr_pulse = pulse_q;

endmodule

// File: tb/tb_tap_ctrl_ir_dr.sv
// Directed scans plus randomized TMS/TDI walk, checked every cycle against a table-driven TAP model.
module tb_tap_ctrl_ir_dr;

    logic       GCLK = 1'b0;
    logic       TRST;
    logic       TMS;
    logic       TDI;
    logic       TDO;
    logic       TDO_EN;
    logic [3:0] state_obs;
    logic [3:0] ir_out;
    logic [7:0] user_dr_in;
    logic [7:0] user_dr_out;
    logic       update_dr_pulse;

    int checks   = 0;
    int failures = 0;

    tap_ctrl_ir_dr dut (
        .GCLK            (GCLK),
        .TRST            (TRST),
        .TMS             (TMS),
        .TDI             (TDI),
        .TDO             (TDO),
        .TDO_EN          (TDO_EN),
        .state_obs       (state_obs),
        .ir_out          (ir_out),
        .user_dr_in      (user_dr_in),
        .user_dr_out     (user_dr_out),
        .update_dr_pulse (update_dr_pulse)
    );

    always #5 GCLK = ~GCLK;

    // Next-state tables indexed by state code, one per TMS value.
    logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                              4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                              4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    logic [3:0]  m_st;
    logic [3:0]  m_ir;
    logic [3:0]  m_irsr;
    logic [31:0] m_dr;
    int          m_len;
    logic [7:0]  m_uout;
    logic        m_pulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 4'hF; m_ir = 4'h1; m_irsr = '0; m_dr = '0; m_len = 1;
        m_uout = '0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic tms, input logic tdi);
        logic [3:0] cur;
        cur     = m_st;
        m_pulse = 1'b0;
        case (cur)
            4'hE: m_irsr = 4'b0001;
            4'hA: m_irsr = (m_irsr >> 1) | {tdi, 3'b000};
            4'hD: m_ir   = m_irsr;
            4'h6: begin
                if (m_ir == 4'h1)      begin m_dr = 32'h1000_0001;     m_len = 32; end
                else if (m_ir == 4'h2) begin m_dr = {24'h0, user_dr_in}; m_len = 8;  end
                else                   begin m_dr = 32'h0;              m_len = 1;  end
            end
            4'h2: m_dr = (m_dr >> 1) | (32'(tdi) << (m_len - 1));
            4'h5: if (m_ir == 4'h2) begin m_uout = m_dr[7:0]; m_pulse = 1'b1; end
            default: ;
        endcase
        m_st = tms ? nxt1[cur] : nxt0[cur];
        if (m_st == 4'hF) m_ir = 4'h1;
    endtask

    // Single compare process: every falling edge, all outputs against the model.
    always @(negedge GCLK) begin
        logic shifting;
        logic exp_tdo;
        #1;
        shifting = (m_st == 4'h2) || (m_st == 4'hA);
        exp_tdo  = (m_st == 4'h2) ? m_dr[0] : ((m_st == 4'hA) ? m_irsr[0] : 1'b0);
        chk("m_state",  32'(state_obs),       32'(m_st));
        chk("m_ir_out", 32'(ir_out),          32'(m_ir));
        chk("m_tdo_en", 32'(TDO_EN),          32'(shifting));
        chk("m_tdo",    32'(TDO),             32'(exp_tdo));
        chk("m_uout",   32'(user_dr_out),     32'(m_uout));
        chk("m_pulse",  32'(update_dr_pulse), 32'(m_pulse));
    end

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge GCLK);
        model_step(tms, tdi);
        @(negedge GCLK);
        #2;
    endtask

    // From SH_x: collects TDO before each shift edge, last bit exits with TMS=1.
    task automatic shift(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = TDO;
            step(i == n - 1, din[i]);
        end
    endtask

    task automatic enter_shift_dr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic load_ir(input logic [3:0] val);
        logic [31:0] cap;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        shift(4, 32'(val), cap);
        chk("ir_capture", 32'(cap[3:0]), 32'h1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("ir_loaded", 32'(ir_out), 32'(val));
    endtask

    task automatic async_reset();
        TRST = 1'b0;
        #1;
        model_reset();
        @(posedge GCLK);
        @(negedge GCLK);
        #2;
        TRST = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap;
        TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; user_dr_in = '0;
        model_reset();
        repeat (2) @(negedge GCLK);
        #2;
        chk("rst_state", 32'(state_obs),   32'hF);
        chk("rst_ir",    32'(ir_out),      32'h1);
        chk("rst_tdoen", 32'(TDO_EN),      32'h0);
        chk("rst_uout",  32'(user_dr_out), 32'h00);
        TRST = 1'b1;
        step(1'b0, 1'b0);
        chk("tlr_to_rti", 32'(state_obs), 32'hC);

        enter_shift_dr();
        shift(32, 32'h0, cap);
        chk("idcode_read", cap, 32'h1000_0001);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        load_ir(4'b0010);
        user_dr_in = 8'h3C;
        enter_shift_dr();
        shift(8, 32'hA5, cap);
        chk("user_tdo", 32'(cap[7:0]), 32'h3C);
        step(1'b1, 1'b0);
        chk("pulse_in_upd", 32'(update_dr_pulse), 32'h0);
        step(1'b0, 1'b0);
        chk("user_out",  32'(user_dr_out),     32'hA5);
        chk("pulse_hi",  32'(update_dr_pulse), 32'h1);
        step(1'b0, 1'b0);
        chk("pulse_lo",  32'(update_dr_pulse), 32'h0);

        load_ir(4'hF);
        enter_shift_dr();
        shift(4, 32'b1101, cap);
        chk("bypass_tdo", 32'(cap[3:0]), 32'b1010);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        enter_shift_dr();
        step(1'b1, 1'b0); chk("walk1", 32'(state_obs), 32'h1);
        step(1'b1, 1'b0); chk("walk2", 32'(state_obs), 32'h5);
        step(1'b1, 1'b0); chk("walk3", 32'(state_obs), 32'h7);
        step(1'b1, 1'b0); chk("walk4", 32'(state_obs), 32'h4);
        step(1'b1, 1'b0); chk("walk5", 32'(state_obs), 32'hF);
        chk("walk_ir",   32'(ir_out),      32'h1);
        chk("walk_uout", 32'(user_dr_out), 32'hA5);
        step(1'b0, 1'b0);

        load_ir(4'b0010);
        user_dr_in = 8'h5A;
        enter_shift_dr();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("abort_pre_tdoen", 32'(TDO_EN), 32'h1);
        TRST = 1'b0;
        #1;
        model_reset();
        chk("abort_state", 32'(state_obs),       32'hF);
        chk("abort_uout",  32'(user_dr_out),     32'h00);
        chk("abort_pulse", 32'(update_dr_pulse), 32'h0);
        chk("abort_ir",    32'(ir_out),          32'h1);
        @(posedge GCLK);
        @(negedge GCLK);
        #2;
        TRST = 1'b1;
        step(1'b0, 1'b0);

        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                user_dr_in = 8'($urandom);
                step($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
